// File: rtl/cache_wr_axi_bridge.sv
// -----------------------------------------------------------------------------
// cache_wr_axi_bridge
//
// Memory-side responder for the cache write-request port. It accepts either a
// dirty-line write-back (LINE_WORDS x 32b INCR burst) or one uncached
// byte/half/word store, and issues it as a single AXI write on AW/W/B. Only one
// transaction is in flight at a time. A line-address probe (chk_addr/chk_hit)
// lets the read path stall reads that target a line still being written back.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   wr_req/wr_type/wr_addr/
//   wr_wstrb/wr_data/wr_rdy    cache write request; accepted on wr_req && wr_rdy
//                              wr_type: 0 byte, 1 half, 2 word, 4 cache line
//   awaddr/awlen/awsize/
//   awvalid/awready            AXI write address channel
//   wdata/wstrb/wlast/
//   wvalid/wready              AXI write data channel
//   bvalid/bready              AXI write response channel (bresp not consumed)
//   chk_addr/chk_hit           line-match probe against the write in flight
// -----------------------------------------------------------------------------
module cache_wr_axi_bridge #(
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_req,
  input  logic [2:0]                 wr_type,
  input  logic [31:0]                wr_addr,
  input  logic [3:0]                 wr_wstrb,
  input  logic [32*LINE_WORDS-1:0]   wr_data,
  output logic                       wr_rdy,
  output logic [31:0]                awaddr,
  output logic [7:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [31:0]                wdata,
  output logic [3:0]                 wstrb,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic                       bvalid,
  output logic                       bready,
  input  logic [31:0]                chk_addr,
  output logic                       chk_hit
);

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_RESP
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

  state_t                     state;
  state_t                     state_nxt;
  logic [CNT_W-1:0]           cnt;
  logic                       aw_done;
  logic                       w_done;
  logic [31:0]                lat_addr;
  logic [2:0]                 lat_type;
  logic [3:0]                 lat_wstrb;
  logic [32*LINE_WORDS-1:0]   lat_data;

  logic                       is_line;
  logic                       accept;
  logic                       aw_hs;
  logic                       w_hs;
  logic                       last_beat;

  assign is_line   = (lat_type == 3'd4);
  assign accept    = wr_req && wr_rdy;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  // Single-beat stores are always on their last beat; lines finish on the top count.
  assign last_beat = is_line ? (cnt == LAST_CNT) : 1'b1;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= W_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. AW and the last W beat may complete in either order,
  // so each side counts as done if it handshakes now or already did.
  always_comb begin
    state_nxt = state;
    unique case (state)
      W_IDLE: if (accept) state_nxt = W_SEND;
      W_SEND: if ((aw_done || aw_hs) && (w_done || (w_hs && last_beat)))
                state_nxt = W_RESP;
      W_RESP: if (bvalid) state_nxt = W_IDLE;
      default: state_nxt = W_IDLE;
    endcase
  end

  // Request latch, beat counter and per-channel completion flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      lat_addr  <= '0;
      lat_type  <= '0;
      lat_wstrb <= '0;
      lat_data  <= '0;
    end else begin
      if (accept) begin
        lat_addr  <= wr_addr;
        lat_type  <= wr_type;
        lat_wstrb <= wr_wstrb;
        lat_data  <= wr_data;
      end
      if (state == W_SEND) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs) begin
          if (last_beat) begin
            w_done <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
      if (state == W_RESP && bvalid) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  // Outputs. AXI payload is derived purely from latched fields and the beat
  // counter, so it cannot move while a valid waits for its ready.
  always_comb begin
    wr_rdy  = (state == W_IDLE);
    awvalid = (state == W_SEND) && !aw_done;
    wvalid  = (state == W_SEND) && !w_done;
    bready  = (state == W_RESP);

    if (is_line) begin
      awaddr = {lat_addr[31:4], 4'h0};
      awlen  = 8'(LINE_WORDS - 1);
      awsize = 3'd2;
      wdata  = lat_data[{cnt, 5'b0} +: 32];
      wstrb  = 4'hF;
    end else begin
      awaddr = lat_addr;
      awlen  = 8'd0;
      // Types 3,5,6,7 fall back to a word-sized beat.
      awsize = (lat_type == 3'd0) ? 3'd0 :
               (lat_type == 3'd1) ? 3'd1 : 3'd2;
      wdata  = lat_data[31:0];
      wstrb  = lat_wstrb;
    end
    wlast = (state == W_SEND) && last_beat;

    // Match against the transaction in flight, or the one being accepted this cycle.
    chk_hit = ((state != W_IDLE) && (chk_addr[31:4] == lat_addr[31:4])) ||
              (accept && (chk_addr[31:4] == wr_addr[31:4]));
  end

endmodule
